// File: rtl/adder_issue_ctrl_pkg.sv
// Shared types and defaults for the two-requester shared-adder issue controller.
// Tags travel alongside each in-flight add so results can be routed home.
package adder_issue_ctrl_pkg;

  localparam int W_DEF   = 32;
  localparam int LAT_DEF = 5;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/adder_tag_pipe.sv
// Shift register of {valid, id} tags, one stage per adder cycle plus the
// operand register stage. Flush clears every valid bit.
module adder_tag_pipe
  import adder_issue_ctrl_pkg::*;
#(
  parameter int STAGES = LAT_DEF + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic any_valid
);

  tag_t [STAGES-1:0] stage_q;
  tag_t [STAGES-1:0] stage_d;

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else begin
      stage_d = {stage_q[STAGES-2:0], tag_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      any_valid = any_valid | stage_q[i].valid;
    end
  end

  assign tag_out = stage_q[STAGES-1];

endmodule

// File: rtl/adder_issue_ctrl.sv
// Round-robin issue of two requesters into one stall-free pipelined adder,
// with subtract folded into add and results routed back by tag.
module adder_issue_ctrl
  import adder_issue_ctrl_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_sub,
  input  logic         hold,
  input  logic         flush,
  output logic [W-1:0] add_x,
  output logic [W-1:0] add_y,
  output logic         add_cin,
  input  logic [W-1:0] add_s,
  input  logic         add_cout,
  output logic         rsp0_valid,
  output logic [W-1:0] rsp0_sum,
  output logic         rsp0_cout,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp1_sum,
  output logic         rsp1_cout,
  output logic         busy
);

  logic         rr_ptr_q, rr_ptr_d;
  logic [W-1:0] add_x_q, add_x_d;
  logic [W-1:0] add_y_q, add_y_d;
  logic         add_cin_q, add_cin_d;
  logic         rsp0_valid_q, rsp0_valid_d;
  logic [W-1:0] rsp0_sum_q, rsp0_sum_d;
  logic         rsp0_cout_q, rsp0_cout_d;
  logic         rsp1_valid_q, rsp1_valid_d;
  logic [W-1:0] rsp1_sum_q, rsp1_sum_d;
  logic         rsp1_cout_q, rsp1_cout_d;

  logic grant0, grant1, accept;
  logic tags_busy;
  tag_t tag_in, tag_last;

  // Handshake: an op transfers on any edge where reqN_valid && reqN_ready.
  // Ready is a pure function of both valids, hold, flush and rr_ptr.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!hold && !flush) begin
      grant0 = req0_valid && (!req1_valid || rr_ptr_q == REQ0);
      grant1 = req1_valid && (!req0_valid || rr_ptr_q == REQ1);
    end
  end

  assign accept       = grant0 | grant1;
  assign tag_in.valid = accept;
  assign tag_in.id    = grant1 ? REQ1 : REQ0;

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    add_x_d   = add_x_q;
    add_y_d   = add_y_q;
    add_cin_d = add_cin_q;
    if (grant0) begin
      rr_ptr_d  = REQ1;
      add_x_d   = req0_a;
      add_y_d   = req0_sub ? ~req0_b : req0_b;
      add_cin_d = req0_sub;
    end else if (grant1) begin
      rr_ptr_d  = REQ0;
      add_x_d   = req1_a;
      add_y_d   = req1_sub ? ~req1_b : req1_b;
      add_cin_d = req1_sub;
    end
  end

  adder_tag_pipe #(
    .STAGES(LAT + 1)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .tag_in   (tag_in),
    .tag_out  (tag_last),
    .any_valid(tags_busy)
  );

  // A tag reaching the last stage on a flush edge is discarded with the rest.
  always_comb begin
    rsp0_valid_d = tag_last.valid && (tag_last.id == REQ0) && !flush;
    rsp1_valid_d = tag_last.valid && (tag_last.id == REQ1) && !flush;
    rsp0_sum_d   = rsp0_valid_d ? add_s    : rsp0_sum_q;
    rsp0_cout_d  = rsp0_valid_d ? add_cout : rsp0_cout_q;
    rsp1_sum_d   = rsp1_valid_d ? add_s    : rsp1_sum_q;
    rsp1_cout_d  = rsp1_valid_d ? add_cout : rsp1_cout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= REQ0;
      add_x_q      <= '0;
      add_y_q      <= '0;
      add_cin_q    <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp0_sum_q   <= '0;
      rsp0_cout_q  <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_sum_q   <= '0;
      rsp1_cout_q  <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      add_x_q      <= add_x_d;
      add_y_q      <= add_y_d;
      add_cin_q    <= add_cin_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_sum_q   <= rsp0_sum_d;
      rsp0_cout_q  <= rsp0_cout_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_sum_q   <= rsp1_sum_d;
      rsp1_cout_q  <= rsp1_cout_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign add_x      = add_x_q;
  assign add_y      = add_y_q;
  assign add_cin    = add_cin_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_sum   = rsp0_sum_q;
  assign rsp0_cout  = rsp0_cout_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_sum   = rsp1_sum_q;
  assign rsp1_cout  = rsp1_cout_q;
  assign busy       = tags_busy | rsp0_valid_q | rsp1_valid_q;

endmodule

// File: tb/tb_adder_issue_ctrl.sv
// Bench for adder_issue_ctrl: behavioural LAT-deep adder, per-requester
// expected-result queues filled at accept and drained at each rsp pulse.
module tb_adder_issue_ctrl;

  localparam int W   = 32;
  localparam int LAT = 5;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_sub;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_sub;
  logic [W-1:0] req1_a, req1_b;
  logic         hold, flush;
  logic [W-1:0] add_x, add_y, add_s;
  logic         add_cin, add_cout;
  logic         rsp0_valid, rsp0_cout, rsp1_valid, rsp1_cout;
  logic [W-1:0] rsp0_sum, rsp1_sum;
  logic         busy;

  logic [W:0] exp0_q[$];
  logic [W:0] exp1_q[$];
  logic [W:0] apipe[LAT];
  int n_checks = 0;
  int n_err    = 0;

  adder_issue_ctrl #(.W(W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_sub(req1_sub),
    .hold(hold), .flush(flush),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .rsp0_valid(rsp0_valid), .rsp0_sum(rsp0_sum), .rsp0_cout(rsp0_cout),
    .rsp1_valid(rsp1_valid), .rsp1_sum(rsp1_sum), .rsp1_cout(rsp1_cout),
    .busy(busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // LAT-cycle pipelined adder model
  always @(posedge clk) begin
    apipe[0] <= {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign add_s    = apipe[LAT-1][W-1:0];
  assign add_cout = apipe[LAT-1][W];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected {cout, sum}; for subtract cout=1 means no borrow (a >= b).
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub);
    if (sub) return {(a >= b), a - b};
    return {1'b0, a} + {1'b0, b};
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_valid && req0_ready) exp0_q.push_back(model(req0_a, req0_b, req0_sub));
      if (req1_valid && req1_ready) exp1_q.push_back(model(req1_a, req1_b, req1_sub));
      check("rsp_onehot", rsp0_valid & rsp1_valid, 0);
      if (rsp0_valid) begin
        check("rsp0_pending", exp0_q.size() > 0, 1);
        if (exp0_q.size() > 0) check("rsp0_result", {rsp0_cout, rsp0_sum}, exp0_q.pop_front());
      end
      if (rsp1_valid) begin
        check("rsp1_pending", exp1_q.size() > 0, 1);
        if (exp1_q.size() > 0) check("rsp1_result", {rsp1_cout, rsp1_sum}, exp1_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic issue(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub);
    logic rdy;
    if (n == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
    end
    rdy = 1'b0;
    for (int k = 0; k < 20 && !rdy; k++) begin
      @(negedge clk);
      rdy = (n == 0) ? req0_ready : req1_ready;
      if (!rdy) @(posedge clk);
    end
    check("issue_ready", rdy, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      #1;
      done = (exp0_q.size() == 0) && (exp1_q.size() == 0) && !busy;
    end
    check("drain_left", exp0_q.size() + exp1_q.size(), 0);
    check("drain_busy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_ops();
    req0_a = $urandom; req0_b = $urandom; req0_sub = 1'($urandom_range(0, 1));
    req1_a = $urandom; req1_b = $urandom; req1_sub = 1'($urandom_range(0, 1));
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    hold = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_add_x", add_x, 0);
    check("rst_add_y", add_y, 0);
    check("rst_add_cin", add_cin, 0);
    check("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_cout, rsp1_cout}, 0);
    check("rst_sums", {rsp0_sum, rsp1_sum}, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single add with latency check
    issue(0, 32'h5, 32'h3, 1'b0);
    check("add_x", add_x, 32'h5);
    check("add_y", add_y, 32'h3);
    check("add_cin", add_cin, 0);
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    check("lat_early", rsp0_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_valid", rsp0_valid, 1);
    check("lat_sum", {rsp0_cout, rsp0_sum}, 33'h8);
    drain();

    // subtract, with and without borrow
    issue(1, 32'h10, 32'h20, 1'b1);
    check("sub_add_y", add_y, 32'hFFFF_FFDF);
    check("sub_add_cin", add_cin, 1);
    issue(1, 32'h20, 32'h10, 1'b1);
    drain();

    // wrap
    issue(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    drain();

    // contention from reset: grants alternate, responses alternate
    reset_pulse();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    randomize_ops();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("cont_ready0", req0_ready, (i % 2 == 0));
      check("cont_ready1", req1_ready, (i % 2 == 1));
      @(posedge clk);
      #1;
      randomize_ops();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (LAT - 2) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("cont_rsp0", rsp0_valid, (i % 2 == 0));
      check("cont_rsp1", rsp1_valid, (i % 2 == 1));
      @(posedge clk);
    end
    #1;
    drain();

    // hold blocks issue and keeps rr_ptr (last grant was req1 -> req0 next)
    hold = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_ready", {req0_ready, req1_ready}, 2'b00);
      @(posedge clk);
      #1;
    end
    hold = 1'b0;
    @(negedge clk);
    check("hold_rr", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // flush two cycles after three issues
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_ops();
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    check("flush_ready", req1_ready, 0);
    check("flush_busy_pre", busy, 1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    req1_valid = 1'b0;
    exp0_q.delete();
    exp1_q.delete();
    @(negedge clk);
    check("flush_busy", busy, 0);
    repeat (12) @(posedge clk);
    #1;
    drain();

    // random traffic
    for (int i = 0; i < 40; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 7) == 0);
      randomize_ops();
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    hold = 1'b0;
    drain();

    // async reset mid-stream
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_ops();
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_add", {add_x, add_y, add_cin}, 0);
    check("arst_rsp", {rsp0_valid, rsp1_valid, rsp0_cout, rsp1_cout}, 0);
    check("arst_sums", {rsp0_sum, rsp1_sum}, 0);
    check("arst_busy", busy, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp0_q.delete();
    exp1_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("arst_quiet_busy", busy, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_issue_ctrl.md
Name: adder_issue_ctrl

Overview:
- Shares one pipelined 32-bit prefix adder (LAT-cycle latency, fully pipelined) between two requesters, for example ALU integer ops and address generation.
- Arbitrates round-robin and registers operands into the adder. Converts subtract into add (inverted B, cin=1).
- Tracks in-flight ops with a tag shift register and routes each registered result back to the requester that issued it.

Parameters:
- W, 32, operand/result width
- LAT, 5, adder latency in cycles from add_x/add_y/add_cin to matching add_s/add_cout (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_a  in  W  operand A
- req0_b  in  W  operand B
- req0_sub  in  1  1 = A-B, 0 = A+B
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  same as requester 0
- hold  in  1  block new issue; in-flight ops complete
- flush  in  1  discard all in-flight ops (synchronous)
- add_x  out  W  adder operand x (registered)
- add_y  out  W  adder operand y (registered)
- add_cin  out  1  adder carry-in (registered)
- add_s  in  W  adder sum
- add_cout  in  1  adder carry-out
- rsp0_valid  out  1  one-cycle result pulse for requester 0
- rsp0_sum  out  W  result
- rsp0_cout  out  1  carry-out; for sub, 1 = no borrow
- rsp1_valid, rsp1_sum, rsp1_cout  same for requester 1
- busy  out  1  any op in flight or result pending

Behaviour:
- Reset (rst_n=0, async): rr_ptr=0, all tag-valid bits=0, add_x/add_y=0, add_cin=0, all rsp*=0, busy=0.
- Grant (combinational): none if hold or flush. If exactly one valid, that one is granted. If both valid, grant req[rr_ptr].
- reqN_ready = grant to N. Ready depends on valid, hold, flush and rr_ptr only; there is no backpressure from the adder.
- On accept at edge E:
  - add_x <= a.
  - add_y <= sub ? ~b : b.
  - add_cin <= sub.
  - Tag stage 0 <= {valid=1, id=N}.
  - rr_ptr <= ~N.
- No accept: add_* hold their previous values. Tag stage 0 valid <= 0. rr_ptr unchanged.
- Tag shift register: LAT+1 stages {valid, id}, shifting every edge. The adder is stall-free, so nothing freezes.
- At the edge where the final tag stage is valid with id=N: rspN_sum <= add_s, rspN_cout <= add_cout, rspN_valid <= 1 for one cycle. The other requester's rsp_valid is 0.
- rsp_sum/cout hold their value when rsp_valid=0.
- Latency: rspN_valid is high in the cycle following edge E+LAT+1 (E = accept edge). Throughput is 1 op/cycle.
- Responses return in issue order. At most one response per cycle, so the two responses never collide.
- flush=1 at edge: all tag-valid bits <= 0 and no accept. Results already registered in rsp* still complete their pulse. add_* hold.
- hold=1: no accept; in-flight ops drain normally; rr_ptr unchanged.
- Requesters must accept rsp unconditionally (no response backpressure).
- busy = OR of all tag-valid bits OR any rsp*_valid.
- Overflow is not detected. The sum wraps modulo 2^W; the carry is reported only through cout.
- Reset mid-operation: all in-flight ops are silently dropped; no rsp pulse is produced for them.

Decomposition:
- Shared package:
  - W and LAT defaults
  - tag struct {valid, id}
  - requester-id constants REQ0=0, REQ1=1
- Sub-module: adder_tag_pipe (parameterised LAT+1-stage {valid, id} shift register with synchronous flush and async reset).
- The arbiter and response routing stay in the top level.

Test Plan:
- Single add: req0 a=0x0000_0005, b=0x0000_0003, sub=0 → req0_ready=1. add_x=5, add_y=3, add_cin=0 next cycle. rsp0_valid after LAT+1 edges with sum=0x8, cout=0.
- Subtract: req1 a=0x10, b=0x20, sub=1 → add_y=0xFFFF_FFDF, add_cin=1. rsp1_sum=0xFFFF_FFF0, rsp1_cout=0. Also a=0x20, b=0x10 → sum=0x10, cout=1.
- Contention: both valid for 4 cycles from reset → grants 0,1,0,1. rsp0/rsp1 alternate on consecutive cycles in issue order, 1 op/cycle.
- Wrap: a=0xFFFF_FFFF, b=0x1, add → sum=0x0, cout=1.
- Flush/hold: issue 3 ops, assert flush 2 cycles later → only the ops already past the final tag stage respond; busy drops to 0. hold=1 with both valid → ready=0, rr_ptr unchanged.
- Async reset: drop rst_n mid-stream between edges → all outputs 0 immediately, busy=0. After release, no stale rsp pulses appear.
